mantissa_multiplier_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 13 +
 rtl/mantissa_normalize.sv | 18 +
 rtl/mantissa_multiplier_seq.sv | 108 ++++++++++
 tb/tb_mantissa_multiplier_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point significand definitions for the sequential multiplier and divider.
package fp_pkg;

  localparam int unsigned FRAC_W = 23;
  localparam logic HIDDEN_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2
  } state_t;

endpackage

// File: rtl/mantissa_normalize.sv
// Maps a 1.0 <= P < 4.0 significand product onto a truncated fraction plus exponent carry.
module mantissa_normalize #(
  parameter int unsigned BIT_WIDTH = 23
) (
  input  logic [2*BIT_WIDTH+1:0] product,
  output logic [BIT_WIDTH-1:0]   frac_c,
  output logic                   carry_c
);

  // Bits below the kept window are dropped by truncation.
  logic unused_low;
  assign unused_low = ^product[BIT_WIDTH-1:0];

  assign carry_c = product[2*BIT_WIDTH+1];
  assign frac_c  = carry_c ? product[2*BIT_WIDTH -: BIT_WIDTH]
                           : product[2*BIT_WIDTH-1 -: BIT_WIDTH];

endmodule

// File: rtl/mantissa_multiplier_seq.sv
// Radix-2 shift-add significand multiplier: one partial product per clock, then normalize.
module mantissa_multiplier_seq
  import fp_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = FRAC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          in0,
  input  logic [31:0]          in1,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 carry_up
);

  localparam int unsigned OP_W   = BIT_WIDTH + 1;
  localparam int unsigned ACC_W  = BIT_WIDTH + 2;
  localparam int unsigned CNT_W  = $clog2(BIT_WIDTH + 1);
  localparam int unsigned PROD_W = 2 * BIT_WIDTH + 2;

  state_t               state, state_d;
  logic [OP_W-1:0]      m_q, m_d, q_q, q_d;
  logic [ACC_W-1:0]     acc_q, acc_d, sum;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] out_d;
  logic                 carry_d, busy_d, done_d;
  logic [PROD_W-1:0]    product;
  logic [BIT_WIDTH-1:0] norm_frac_c;
  logic                 norm_carry_c;

  // Fraction bits above BIT_WIDTH are don't-care.
  logic unused_bits;
  assign unused_bits = ^{in0[31:BIT_WIDTH], in1[31:BIT_WIDTH]};

  // Accumulator top bit is always clear once all partial products are in.
  assign product = {acc_q[BIT_WIDTH:0], q_q};
  assign sum     = acc_q + (q_q[0] ? ACC_W'(m_q) : ACC_W'(0));

  mantissa_normalize #(.BIT_WIDTH(BIT_WIDTH)) u_norm (
    .product (product),
    .frac_c  (norm_frac_c),
    .carry_c (norm_carry_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      m_q      <= '0;
      q_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out      <= '0;
      carry_up <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out      <= out_d;
      carry_up <= carry_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out;
    carry_d = carry_up;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          m_d     = {HIDDEN_BIT, in0[BIT_WIDTH-1:0]};
          q_d     = {HIDDEN_BIT, in1[BIT_WIDTH-1:0]};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Add-if-set, then shift {carry,A,Q} right by one.
        acc_d = {1'b0, sum[ACC_W-1:1]};
        q_d   = {sum[0], q_q[OP_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIT_WIDTH)) state_d = ST_NORM;
      end
      ST_NORM: begin
        out_d   = norm_frac_c;
        carry_d = norm_carry_c;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Directed checks of the sequential significand multiplier at 23-bit and 4-bit fraction widths.
module tb_mantissa_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] in0_a = '0, in1_a = '0, in0_b = '0, in1_b = '0;
  logic        busy_a, done_a, carry_a, busy_b, done_b, carry_b;
  logic [22:0] out_a;
  logic [3:0]  out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mantissa_multiplier_seq #(.BIT_WIDTH(23)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in0(in0_a), .in1(in1_a),
    .busy(busy_a), .done(done_a), .out(out_a), .carry_up(carry_a)
  );

  mantissa_multiplier_seq #(.BIT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in0(in0_b), .in1(in1_b),
    .busy(busy_b), .done(done_b), .out(out_b), .carry_up(carry_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start an operation on the 23-bit unit; returns edges from start sample to done (bounded).
  task automatic run_a(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in0_a = a; in1_a = b; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_b(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    in0_b = {28'hFFFFFFF, a}; in1_b = {28'hA5A5A5A, b}; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, pulses, first_done;
    logic [9:0] p;
    logic [3:0] exp_frac;
    logic       exp_carry;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_carry_a", 32'(carry_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1.0 x 1.0
    run_a(32'h0, 32'h0, lat);
    check("one_lat", 32'(lat), 32'd25);
    check("one_out", 32'(out_a), 32'h000000);
    check("one_carry", 32'(carry_a), 32'd0);
    check("one_busy_done_cycle", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("one_done_after", 32'(done_a), 32'd0);
    check("one_busy_after", 32'(busy_a), 32'd0);

    // 1.5 x 1.5 = 2.25
    run_a(32'h400000, 32'h400000, lat);
    check("x15_lat", 32'(lat), 32'd25);
    check("x15_out", 32'(out_a), 32'h100000);
    check("x15_carry", 32'(carry_a), 32'd1);

    // Max fractions with garbage upper bits on in0
    run_a(32'hFF7FFFFF, 32'h007FFFFF, lat);
    check("max_lat", 32'(lat), 32'd25);
    check("max_out", 32'(out_a), 32'h7FFFFE);
    check("max_carry", 32'(carry_a), 32'd1);

    // 1.5 x 1.0 then back-to-back 1.5 x 1.5 accepted in the done cycle
    run_a(32'h400000, 32'h0, lat);
    check("b2b1_lat", 32'(lat), 32'd25);
    check("b2b1_out", 32'(out_a), 32'h400000);
    check("b2b1_carry", 32'(carry_a), 32'd0);
    run_a(32'h400000, 32'h400000, lat);
    check("b2b2_lat", 32'(lat), 32'd25);
    check("b2b2_out", 32'(out_a), 32'h100000);
    check("b2b2_carry", 32'(carry_a), 32'd1);

    // Results hold while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold_out", 32'(out_a), 32'h100000);
    check("hold_carry", 32'(carry_a), 32'd1);
    check("hold_done", 32'(done_a), 32'd0);

    // start while busy is ignored; operand changes while busy have no effect
    @(negedge clk);
    in0_a = 32'h400000; in1_a = 32'h0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    pulses = 0; first_done = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        check("busy_mid_op", 32'(busy_a), 32'd1);
        in0_a = 32'h0; in1_a = 32'h400000; start_a = 1'b1;
      end
      if (c == 7) start_a = 1'b0;
      @(posedge clk); #1;
      if (done_a) begin
        pulses++;
        if (first_done < 0) first_done = c;
      end
      if (first_done == c) begin
        check("ign_out", 32'(out_a), 32'h400000);
        check("ign_carry", 32'(carry_a), 32'd0);
      end
    end
    check("ign_first_done", 32'(first_done), 32'd25);
    check("ign_pulses", 32'(pulses), 32'd1);

    // Reset ten cycles into an operation discards it
    run_a(32'h400000, 32'h400000, lat);
    check("pre_rst_carry", 32'(carry_a), 32'd1);
    @(negedge clk);
    in0_a = 32'h7FFFFF; in1_a = 32'h7FFFFF; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_out", 32'(out_a), 32'd0);
    check("mid_rst_carry", 32'(carry_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) pulses++;
    end
    check("post_rst_quiet", 32'(pulses), 32'd0);
    run_a(32'h400000, 32'h400000, lat);
    check("post_rst_lat", 32'(lat), 32'd25);
    check("post_rst_out", 32'(out_a), 32'h100000);
    check("post_rst_carry", 32'(carry_a), 32'd1);

    // 4-bit exhaustive against the product/normalize/truncate model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        p = 10'(16 + a) * 10'(16 + b);
        exp_carry = p[9];
        exp_frac  = exp_carry ? p[8:5] : p[7:4];
        run_b(4'(a), 4'(b), lat);
        check($sformatf("bw4_lat_%0d_%0d", a, b), 32'(lat), 32'd6);
        check($sformatf("bw4_out_%0d_%0d", a, b), 32'(out_b), 32'(exp_frac));
        check($sformatf("bw4_carry_%0d_%0d", a, b), 32'(carry_b), 32'(exp_carry));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
